// File: rtl/sap1_control_decoder.sv
// SAP-1 control decoder: maps the one-hot T-state and IR opcode to the 12-bit control word,
// and keeps the halt latch, sticky error flags and the retired-instruction counter.
module sap1_control_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [5:0]       State,
  input  logic [3:0]       opcode,
  output logic [11:0]      con,
  output logic             hlt,
  output logic             ill_op,
  output logic             state_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Control word bit order MSB..LSB: Cp Ep Lm_n CE_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n
  localparam logic [11:0] CW_NOP     = 12'h3E3;
  localparam logic [11:0] CW_FETCH1  = 12'h5E3;
  localparam logic [11:0] CW_FETCH2  = 12'hBE3;
  localparam logic [11:0] CW_FETCH3  = 12'h263;
  localparam logic [11:0] CW_IR_MAR  = 12'h1A3;
  localparam logic [11:0] CW_RAM_A   = 12'h2C3;
  localparam logic [11:0] CW_RAM_B   = 12'h2E1;
  localparam logic [11:0] CW_ALU_ADD = 12'h3C7;
  localparam logic [11:0] CW_ALU_SUB = 12'h3CF;
  localparam logic [11:0] CW_A_OUT   = 12'h3F2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic is_onehot(input logic [5:0] s);
    return (s != 6'd0) && ((s & (s - 6'd1)) == 6'd0);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

  logic state_ok;
  assign state_ok = is_onehot(State);

  // Combinational decode; reset, halt and a malformed State all collapse to NOP
  always_comb begin
    con = CW_NOP;
    if (clr || hlt || !state_ok) begin
      con = CW_NOP;
    end else begin
      unique case (State)
        T1: con = CW_FETCH1;
        T2: con = CW_FETCH2;
        T3: con = CW_FETCH3;
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) con = CW_IR_MAR;
          else if (opcode == OP_OUT) con = CW_A_OUT;
        end
        T5: begin
          if (opcode == OP_LDA) con = CW_RAM_A;
          else if (opcode == OP_ADD || opcode == OP_SUB) con = CW_RAM_B;
        end
        T6: begin
          if (opcode == OP_ADD) con = CW_ALU_ADD;
          else if (opcode == OP_SUB) con = CW_ALU_SUB;
        end
        default: con = CW_NOP;
      endcase
    end
  end

  // State updates on the falling edge, in step with the ring counter
  always_ff @(negedge clk) begin
    if (clr) begin
      hlt       <= 1'b0;
      ill_op    <= 1'b0;
      state_err <= 1'b0;
      instr_cnt <= '0;
    end else begin
      if (!state_ok) state_err <= 1'b1;
      if (!hlt && State == T4) begin
        if (opcode == OP_HLT) hlt <= 1'b1;
        else if (!is_legal(opcode)) ill_op <= 1'b1;
      end
      // HLT never reaches this point un-halted, so it does not retire
      if (!hlt && State == T6) instr_cnt <= instr_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_sap1_control_decoder.sv
// Directed bench for sap1_control_decoder: default-width and 2-bit-counter instances share
// stimulus; expected values go through a scoreboard queue and are checked with assertions.
module tb_sap1_control_decoder;

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;
  localparam logic [11:0] NOP = 12'h3E3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic [5:0]  State;
  logic [3:0]  opcode;
  logic [11:0] con_a, con_b;
  logic        hlt_a, hlt_b, ill_a, ill_b, err_a, err_b;
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;

  sap1_control_decoder dut (
    .clk(clk), .clr(clr), .State(State), .opcode(opcode), .con(con_a),
    .hlt(hlt_a), .ill_op(ill_a), .state_err(err_a), .instr_cnt(cnt_a)
  );

  sap1_control_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .State(State), .opcode(opcode), .con(con_b),
    .hlt(hlt_b), .ill_op(ill_b), .state_err(err_b), .instr_cnt(cnt_b)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  bit hlt_m = 0, ill_m = 0, err_m = 0;
  int cnt_m = 0;

  function automatic logic [31:0] observe(input string tag);
    case (tag)
      "con":  return 32'(con_a);
      "con2": return 32'(con_b);
      "hlt":  return 32'(hlt_a);
      "hlt2": return 32'(hlt_b);
      "ill":  return 32'(ill_a);
      "ill2": return 32'(ill_b);
      "err":  return 32'(err_a);
      "err2": return 32'(err_b);
      "cnt":  return 32'(cnt_a);
      "cnt2": return 32'(cnt_b);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check_all();
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] obs;
      e = sb.pop_front();
      obs = observe(e.tag);
      n_chk++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic push_con(input logic [11:0] exp_con);
    sb.push_back('{"con", 32'(exp_con)});
    sb.push_back('{"con2", 32'(exp_con)});
    check_all();
  endtask

  // Drive new inputs just after the rising edge, then check the combinational word
  task automatic drive(input logic [5:0] st, input logic [3:0] op, input logic c,
                       input logic [11:0] exp_con);
    @(posedge clk);
    State = st; opcode = op; clr = c;
    #1;
    push_con(exp_con);
  endtask

  task automatic poke(input logic [3:0] op, input logic [11:0] exp_con);
    opcode = op;
    #1;
    push_con(exp_con);
  endtask

  // Advance the flag model with the current inputs, cross the falling edge, then compare
  task automatic tick();
    bit was_hlt;
    was_hlt = hlt_m;
    if (clr) begin
      hlt_m = 0; ill_m = 0; err_m = 0; cnt_m = 0;
    end else begin
      if ($countones(State) != 1) err_m = 1;
      if (!was_hlt && State == T4) begin
        if (opcode == 4'hF) hlt_m = 1;
        else if (!(opcode inside {4'h0, 4'h1, 4'h2, 4'hE})) ill_m = 1;
      end
      if (!was_hlt && State == T6) cnt_m++;
    end
    @(negedge clk);
    #1;
    sb.push_back('{"hlt",  32'(hlt_m)});
    sb.push_back('{"hlt2", 32'(hlt_m)});
    sb.push_back('{"ill",  32'(ill_m)});
    sb.push_back('{"ill2", 32'(ill_m)});
    sb.push_back('{"err",  32'(err_m)});
    sb.push_back('{"err2", 32'(err_m)});
    sb.push_back('{"cnt",  32'(cnt_m % 256)});
    sb.push_back('{"cnt2", 32'(cnt_m % 4)});
    check_all();
  endtask

  task automatic instr(input logic [3:0] op, input logic [3:0] fop,
                       input logic [11:0] e1, input logic [11:0] e2, input logic [11:0] e3,
                       input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
    drive(T1, fop, 1'b0, e1); tick();
    drive(T2, fop, 1'b0, e2); tick();
    drive(T3, fop, 1'b0, e3); tick();
    drive(T4, op,  1'b0, e4); tick();
    drive(T5, op,  1'b0, e5); tick();
    drive(T6, op,  1'b0, e6); tick();
  endtask

  initial begin
    clr = 1'b1; State = 6'd0; opcode = 4'd0;

    drive(6'd0, 4'h0, 1'b1, NOP); tick();
    drive(6'd0, 4'h0, 1'b1, NOP); tick();

    instr(4'h0, 4'h0, 12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, NOP);       // LDA
    instr(4'h1, 4'hF, 12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3C7);   // ADD, junk opcode in fetch
    instr(4'h2, 4'h2, 12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2E1, 12'h3CF);   // SUB
    instr(4'hE, 4'hE, 12'h5E3, 12'hBE3, 12'h263, 12'h3F2, NOP, NOP);           // OUT, 2-bit wraps
    instr(4'h5, 4'h5, 12'h5E3, 12'hBE3, 12'h263, NOP, NOP, NOP);               // illegal, retires

    // Opcode changes in T4 show up without a clock, then clear lands mid-ADD
    drive(T1, 4'h1, 1'b0, 12'h5E3); tick();
    drive(T2, 4'h1, 1'b0, 12'hBE3); tick();
    drive(T3, 4'h1, 1'b0, 12'h263); tick();
    drive(T4, 4'h1, 1'b0, 12'h1A3);
    poke(4'hE, 12'h3F2);
    poke(4'h7, NOP);
    poke(4'h1, 12'h1A3);
    tick();
    drive(T5, 4'h1, 1'b1, NOP); tick();

    // Malformed State words
    drive(T1, 4'h0, 1'b0, 12'h5E3); tick();
    drive(6'b000011, 4'h1, 1'b0, NOP); tick();
    drive(6'b000000, 4'h1, 1'b0, NOP); tick();
    instr(4'h0, 4'h0, 12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, NOP);

    // HLT, then everything is NOP and the counter holds until clear
    instr(4'hF, 4'hF, 12'h5E3, 12'hBE3, 12'h263, NOP, NOP, NOP);
    instr(4'h1, 4'h1, NOP, NOP, NOP, NOP, NOP, NOP);
    drive(T1, 4'h0, 1'b1, NOP); tick();
    drive(T1, 4'h0, 1'b0, 12'h5E3); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sap1_control_decoder.md
Name: sap1_control_decoder

Overview:
- Consumer end of the SAP-1 T-state ring counter. Takes the 6-bit one-hot `State` bus (T1..T6) and the 4-bit opcode from the instruction register.
- Produces the 12-bit SAP-1 control word for each T-state.
- Keeps a halt latch, a sticky illegal-opcode flag, a sticky ring-state error flag and a count of retired instructions.
- Sits between `Ring_counter`/IR and the datapath (PC, MAR, RAM, IR, A, ALU, B, OUT).

Parameters:
- `CNT_W`, default 8: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock. All internal state updates on the negative edge, matching the ring counter.
- `clr`  in  1  reset, synchronous, active-high.
- `State`  in  6  one-hot T-state from the ring counter. bit0 = T1 … bit5 = T6.
- `opcode`  in  4  IR upper nibble. Valid from T4 onward.
- `con`  out  12  control word, combinational. Bit order MSB..LSB: Cp Ep Lm_n CE_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n.
- `hlt`  out  1  registered halt flag. Used externally to gate the clock.
- `ill_op`  out  1  sticky: an undefined opcode was executed.
- `state_err`  out  1  sticky: `State` was not exactly one-hot at a sampling edge.
- `instr_cnt`  out  `CNT_W`  retired-instruction count.

Behaviour:
- Reset:
  - `clr` is sampled on the negedge of `clk`.
  - On reset: `hlt`=0, `ill_op`=0, `state_err`=0, `instr_cnt`=0.
  - While `clr`=1, `con` is forced to NOP = 12'h3E3.
  - `clr` has priority over every other event, including mid-instruction and while halted.
- Control word is combinational from `State` and `opcode`. NOP (all inactive) = 12'h3E3.
- Fetch (all opcodes):
  - T1 = 12'h5E3 (Ep, Lm_n)
  - T2 = 12'hBE3 (Cp)
  - T3 = 12'h263 (CE_n, Li_n)
- LDA, opcode 0000: T4 = 12'h1A3 (Lm_n, Ei_n); T5 = 12'h2C3 (CE_n, La_n); T6 = NOP.
- ADD, opcode 0001: T4 = 12'h1A3; T5 = 12'h2E1 (CE_n, Lb_n); T6 = 12'h3C7 (La_n, Eu).
- SUB, opcode 0010: T4 = 12'h1A3; T5 = 12'h2E1; T6 = 12'h3CF (La_n, Eu, Su).
- OUT, opcode 1110: T4 = 12'h3F2 (Ea, Lo_n); T5 = NOP; T6 = NOP.
- HLT, opcode 1111: T4..T6 = NOP. At the negedge ending T4 (`State`=6'b001000), `hlt` <= 1.
- Any other opcode:
  - T4..T6 = NOP.
  - At the negedge ending T4, `ill_op` <= 1 (sticky until `clr`).
  - The instruction still retires.
- Halted (`hlt`=1):
  - `con` is forced to NOP for all T-states.
  - `instr_cnt` is frozen.
  - `hlt` holds until `clr`. Only `clr` clears it.
- Instruction counter:
  - Increments at the negedge ending T6 (`State`=6'b100000) when `hlt`=0.
  - Wraps 2^`CNT_W`-1 -> 0 with no flag.
  - HLT does not retire: `hlt` is set before its T6.
- State check:
  - At every negedge with `clr`=0, if `State` is not exactly one-hot, `state_err` <= 1 (sticky).
  - When `State` is not one-hot, `con` = NOP regardless of opcode.
- `opcode` is ignored during T1..T3.
- A change of `opcode` during T4..T6 is reflected immediately in `con`; no latching.

Test Plan:
- Reset: `clr`=1 for 2 negedges, then `State`=T1 -> `con`=5E3; `hlt`, `ill_op`, `state_err` = 0; `instr_cnt`=0.
- LDA then ADD then SUB, stepping T1..T6 each -> `con` sequences as listed, e.g. ADD T6 = 3C7, SUB T6 = 3CF. `instr_cnt`=3 after the third T6.
- OUT (1110) -> T4 `con`=3F2, T5/T6 = 3E3. HLT (1111) -> `hlt`=1 after the T4 negedge; all later T-states give `con`=3E3; `instr_cnt` unchanged.
- Opcode 0101 -> `con`=3E3 for T4..T6, `ill_op`=1 after the T4 negedge, `instr_cnt` +1. Then `clr` -> `ill_op`=0.
- `State`=6'b000011 at one negedge -> `con`=3E3 and `state_err`=1. Stays 1 through later valid states until `clr`.
- `CNT_W`=2: run 5 instructions -> `instr_cnt` goes 1,2,3,0,1. Assert `clr` during T5 of an ADD -> all flags 0, `con`=3E3 while `clr`=1.
